rom_scan_ctrl: RTL and testbench

ROM_SCAN_CTRL -- requirements
Module: rom_scan_ctrl

---
 rtl/rom_test_pkg.sv | 25 ++
 rtl/rom_sig_misr.sv | 37 +++
 rtl/rom_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_rom_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_test_pkg.sv
// Shared types and the signature step for the ROM scan controller.
package rom_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int unsigned SIG_MAX_W = 32;

    // Rotate-left-by-1 within 'width' bits, then XOR the new word in.
    function automatic logic [SIG_MAX_W-1:0] sig_step(
        input logic [SIG_MAX_W-1:0] sig,
        input logic [SIG_MAX_W-1:0] word,
        input int unsigned          width
    );
        logic [SIG_MAX_W-1:0] mask;
        logic [SIG_MAX_W-1:0] rot;
        mask = (width >= SIG_MAX_W) ? '1 : ((SIG_MAX_W'(1) << width) - SIG_MAX_W'(1));
        rot  = ((sig << 1) | (sig >> (width - 1))) & mask;
        return rot ^ (word & mask);
    endfunction

endpackage

// File: rtl/rom_sig_misr.sv
// Scan signature register: synchronous clear, enabled rotate/XOR step.
module rom_sig_misr
    import rom_test_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] sig
);

    logic [DATA_W-1:0] sig_q;
    logic [DATA_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = DATA_W'(sig_step(SIG_MAX_W'(sig_q), SIG_MAX_W'(data_in), DATA_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/rom_scan_ctrl.sv
// ROM read/scan controller: single reads or address-incrementing scans over
// one selected ROM channel, with a fixed read latency and a scan signature.
module rom_scan_ctrl
    import rom_test_pkg::*;
#(
    parameter  int ADDR_W = 14,
    parameter  int DATA_W = 10,
    parameter  int N_ROM  = 3,
    parameter  int RD_LAT = 1,
    localparam int SEL_W  = (N_ROM > 1) ? $clog2(N_ROM) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [ADDR_W-1:0]       cfg_len,
    input  logic [SEL_W-1:0]        cfg_sel,
    input  logic                    cmd_read,
    input  logic                    cmd_scan,
    input  logic                    cmd_abort,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_W-1:0]       rd_data,
    output logic [DATA_W-1:0]       sig,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [N_ROM*DATA_W-1:0] rom_data
);

    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [3:0]        lat_q, lat_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              scan_q, scan_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              misr_clear;
    logic              misr_en;
    logic [DATA_W-1:0] word;

    // Out-of-range channel selects read as zero.
    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < N_ROM; k++) begin
            if (sel_q == SEL_W'(k)) begin
                word = rom_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        lat_d      = lat_q;
        sel_d      = sel_q;
        scan_d     = scan_q;
        rd_d       = rd_q;
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_scan || cmd_read) begin
                    sel_d      = cfg_sel;
                    scan_d     = cmd_scan;
                    addr_d     = cfg_addr;
                    lat_d      = '0;
                    rem_d      = cmd_scan ? cfg_len : '0;
                    misr_clear = cmd_scan;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                end else if (lat_q == LAT_LAST) begin
                    rd_d    = word;
                    misr_en = scan_q;
                    if (rem_q != '0) begin
                        addr_d = addr_q + 1'b1;
                        rem_d  = rem_q - 1'b1;
                        lat_d  = '0;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            lat_q   <= '0;
            sel_q   <= '0;
            scan_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            lat_q   <= lat_d;
            sel_q   <= sel_d;
            scan_q  <= scan_d;
            rd_q    <= rd_d;
        end
    end

    rom_sig_misr #(
        .DATA_W (DATA_W)
    ) u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (misr_clear),
        .enable  (misr_en),
        .data_in (rd_d),
        .sig     (sig)
    );

    assign busy     = (state_q != IDLE);
    // An abort arriving in FIN suppresses the completion pulse.
    assign done     = (state_q == FIN) && !cmd_abort;
    assign rd_data  = rd_q;
    assign rom_addr = addr_q;

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Bench: two controllers (RD_LAT=1 and RD_LAT=3) share one command stream;
// results are checked against a word-list model of reads and scans.
module tb_rom_scan_ctrl;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 10;
    localparam int N_ROM  = 3;
    localparam int SEL_W  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [ADDR_W-1:0] cfg_len = '0;
    logic [SEL_W-1:0]  cfg_sel = '0;
    logic cmd_read = 1'b0, cmd_scan = 1'b0, cmd_abort = 1'b0;

    logic busy1, done1, busy3, done3;
    logic [DATA_W-1:0] rd1, sig1, rd3, sig3;
    logic [ADDR_W-1:0] ra1, ra3;
    logic [N_ROM*DATA_W-1:0] rom1, rom3;
    logic [ADDR_W-1:0] d3_0, d3_1;

    function automatic logic [DATA_W-1:0] rom_word(input int k, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] key;
        key = DATA_W'((k * 'h55) % 1024);
        return a[DATA_W-1:0] ^ key;
    endfunction

    function automatic logic [DATA_W-1:0] sig_ref(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] w);
        return DATA_W'(((int'(s) * 2) % 1024) + (int'(s) / 512)) ^ w;
    endfunction

    // ROM models: RD_LAT=1 is combinational, RD_LAT=3 has a two-stage address delay.
    always @(posedge clk) begin
        d3_0 <= ra3;
        d3_1 <= d3_0;
    end
    always @* begin
        for (int k = 0; k < N_ROM; k++) begin
            rom1[k*DATA_W +: DATA_W] = rom_word(k, ra1);
            rom3[k*DATA_W +: DATA_W] = rom_word(k, d3_1);
        end
    end

    rom_scan_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_ROM(N_ROM), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_sel(cfg_sel),
        .cmd_read(cmd_read), .cmd_scan(cmd_scan), .cmd_abort(cmd_abort),
        .busy(busy1), .done(done1), .rd_data(rd1), .sig(sig1), .rom_addr(ra1), .rom_data(rom1));

    rom_scan_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_ROM(N_ROM), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_sel(cfg_sel),
        .cmd_read(cmd_read), .cmd_scan(cmd_scan), .cmd_abort(cmd_abort),
        .busy(busy3), .done(done3), .rd_data(rd3), .sig(sig3), .rom_addr(ra3), .rom_data(rom3));

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic              scan;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] len;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] exp_rd;
        logic [DATA_W-1:0] exp_sig;
        int                exp_b1;
        int                exp_b3;
    } vec_t;

    logic [DATA_W-1:0] m_sig = '0;

    // Reads n consecutive words (wrapping) from channel s; signature folds them all in.
    task automatic scan_model(input logic [ADDR_W-1:0] a, input int n, input logic [SEL_W-1:0] s,
                              input logic [DATA_W-1:0] sig_in,
                              output logic [DATA_W-1:0] erd, output logic [DATA_W-1:0] esig);
        logic [ADDR_W-1:0] ad;
        esig = sig_in;
        erd  = '0;
        for (int i = 0; i < n; i++) begin
            ad   = ADDR_W'((int'(a) + i) % (1 << ADDR_W));
            erd  = (int'(s) < N_ROM) ? rom_word(int'(s), ad) : '0;
            esig = sig_ref(esig, erd);
        end
    endtask

    task automatic fill_expected(inout vec_t v);
        int n;
        logic [DATA_W-1:0] erd, esig;
        n = v.scan ? int'(v.len) + 1 : 1;
        scan_model(v.addr, n, v.sel, '0, erd, esig);
        v.exp_rd = erd;
        if (v.scan) m_sig = esig;
        v.exp_sig = m_sig;
        v.exp_b1  = n * 1 + 1;
        v.exp_b3  = n * 3 + 1;
    endtask

    task automatic run_cmd(input vec_t v, input int poke,
                           output int b1, output int b3, output int n1, output int n3, output bit to);
        @(negedge clk);
        cmd_scan = v.scan; cmd_read = v.rd; cfg_addr = v.addr; cfg_len = v.len; cfg_sel = v.sel;
        @(negedge clk);
        cmd_scan = 1'b0; cmd_read = 1'b0;
        cfg_addr = ADDR_W'($urandom); cfg_len = ADDR_W'($urandom); cfg_sel = SEL_W'($urandom);
        b1 = 0; b3 = 0; n1 = 0; n3 = 0; to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (busy1) b1++;
            if (busy3) b3++;
            if (done1) n1++;
            if (done3) n3++;
            if (!busy1 && !busy3) begin
                to = 1'b0;
                break;
            end
            cmd_read = (i == poke);
            @(negedge clk);
        end
        cmd_read = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag, input int poke);
        int b1, b3, n1, n3;
        bit to;
        run_cmd(v, poke, b1, b3, n1, n3, to);
        check({tag, "_timeout"}, 32'(to), 32'd0);
        check({tag, "_rd1"}, 32'(rd1), 32'(v.exp_rd));
        check({tag, "_rd3"}, 32'(rd3), 32'(v.exp_rd));
        check({tag, "_sig1"}, 32'(sig1), 32'(v.exp_sig));
        check({tag, "_sig3"}, 32'(sig3), 32'(v.exp_sig));
        check({tag, "_busy1"}, 32'(b1), 32'(v.exp_b1));
        check({tag, "_busy3"}, 32'(b3), 32'(v.exp_b3));
        check({tag, "_done1"}, 32'(n1), 32'd1);
        check({tag, "_done3"}, 32'(n3), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (busy1 || busy3); i++) @(negedge clk);
        check("idle_reached", 32'(busy1 | busy3), 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        vec_t v;
        logic [DATA_W-1:0] erd, esig;
        logic [ADDR_W-1:0] ra_log[10];
        logic [DATA_W-1:0] rd_log[10];
        logic              dn_log[10];
        int ndone;

        tbl[0] = '{1'b1, 1'b0, 14'h0000, 14'd3, 2'd0, '0, '0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 14'h02AB, 14'd9, 2'd2, '0, '0, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 14'h0100, 14'd0, 2'd3, '0, '0, 0, 0};
        tbl[3] = '{1'b1, 1'b0, 14'h3FFC, 14'd5, 2'd1, '0, '0, 0, 0};
        tbl[4] = '{1'b1, 1'b0, 14'h0155, 14'd0, 2'd3, '0, '0, 0, 0};
        tbl[5] = '{1'b0, 1'b1, 14'h03FF, 14'd2, 2'd0, '0, '0, 0, 0};
        for (int i = 0; i < 6; i++) fill_expected(tbl[i]);

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'({busy1, busy3}), 32'd0);
        check("rst_done", 32'({done1, done3}), 32'd0);
        check("rst_rd", 32'({rd1, rd3}), 32'd0);
        check("rst_sig", 32'({sig1, sig3}), 32'd0);
        check("rst_addr", 32'({ra1, ra3}), 32'd0);

        // First edge after reset release accepts a single read.
        rst_n = 1'b1; cmd_read = 1'b1; cfg_addr = 14'h123; cfg_sel = 2'd1; cfg_len = '0;
        @(negedge clk);
        cmd_read = 1'b0; cfg_addr = 14'h2222; cfg_sel = 2'd0;
        check("r37_busy_acc", 32'(busy1), 32'd1);
        check("r37_rd_pre", 32'(rd1), 32'd0);
        check("r37_done_pre", 32'(done1), 32'd0);
        @(negedge clk);
        check("r37_rd", 32'(rd1), 32'(rom_word(1, 14'h123)));
        check("r37_done", 32'(done1), 32'd1);
        check("r37_sig", 32'(sig1), 32'd0);
        @(negedge clk);
        check("r37_done_end", 32'(done1), 32'd0);
        check("r37_busy_end", 32'(busy1), 32'd0);
        wait_idle();
        check("r37_rd3", 32'(rd3), 32'(rom_word(1, 14'h123)));

        for (int i = 0; i < 6; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i), -1);

        // Wrapping scan on the RD_LAT=3 channel, traced per cycle.
        @(negedge clk);
        cmd_scan = 1'b1; cfg_addr = 14'h3FFE; cfg_len = 14'd2; cfg_sel = 2'd2;
        @(negedge clk);
        cmd_scan = 1'b0; cfg_addr = '0; cfg_len = '0; cfg_sel = '0;
        for (int k = 0; k < 10; k++) begin
            ra_log[k] = ra3; rd_log[k] = rd3; dn_log[k] = done3;
            if (k < 9) @(negedge clk);
        end
        check("r39_addr0", 32'(ra_log[0]), 32'h3FFE);
        check("r39_addr2", 32'(ra_log[2]), 32'h3FFE);
        check("r39_addr3", 32'(ra_log[3]), 32'h3FFF);
        check("r39_addr6", 32'(ra_log[6]), 32'h0000);
        check("r39_rd3", 32'(rd_log[3]), 32'(rom_word(2, 14'h3FFE)));
        check("r39_rd6", 32'(rd_log[6]), 32'(rom_word(2, 14'h3FFF)));
        check("r39_rd9", 32'(rd_log[9]), 32'(rom_word(2, 14'h0000)));
        check("r39_done8", 32'(dn_log[8]), 32'd0);
        check("r39_done9", 32'(dn_log[9]), 32'd1);
        scan_model(14'h3FFE, 3, 2'd2, '0, erd, esig);
        m_sig = esig;
        check("r39_sig3", 32'(sig3), 32'(esig));
        wait_idle();

        // Simultaneous scan+read, then a read while busy.
        v = '{1'b1, 1'b1, 14'h0A0F, 14'd3, 2'd1, '0, '0, 0, 0};
        fill_expected(v);
        apply_vec(v, "r40", 2);

        // Randomized commands.
        for (int r = 0; r < 30; r++) begin
            v.scan = 1'($urandom_range(0, 1));
            v.rd   = v.scan ? 1'($urandom_range(0, 1)) : 1'b1;
            v.addr = ($urandom_range(0, 3) == 0) ? ADDR_W'(14'h3FF0 + $urandom_range(0, 15))
                                                 : ADDR_W'($urandom);
            v.len  = ADDR_W'($urandom_range(0, 15));
            v.sel  = SEL_W'($urandom_range(0, 3));
            fill_expected(v);
            apply_vec(v, $sformatf("rnd%0d", r), -1);
        end

        // Abort mid-scan.
        @(negedge clk);
        cmd_scan = 1'b1; cfg_addr = 14'h0040; cfg_len = 14'd7; cfg_sel = 2'd1;
        @(negedge clk);
        cmd_scan = 1'b0;
        ndone = 0;
        repeat (3) begin
            if (done1 || done3) ndone++;
            @(negedge clk);
        end
        if (done1 || done3) ndone++;
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        if (done1 || done3) ndone++;
        check("r41_abort_busy1", 32'(busy1), 32'd0);
        check("r41_abort_busy3", 32'(busy3), 32'd0);
        check("r41_abort_nodone", 32'(ndone), 32'd0);
        scan_model(14'h0040, 3, 2'd1, '0, erd, esig);
        check("r41_abort_rd1", 32'(rd1), 32'(erd));
        check("r41_abort_sig1", 32'(sig1), 32'(esig));
        scan_model(14'h0040, 1, 2'd1, '0, erd, esig);
        check("r41_abort_rd3", 32'(rd3), 32'(erd));
        check("r41_abort_sig3", 32'(sig3), 32'(esig));
        repeat (2) @(negedge clk);
        check("r41_abort_stay", 32'({busy1, busy3, done1, done3}), 32'd0);

        // Asynchronous reset mid-scan.
        cmd_scan = 1'b1; cfg_addr = 14'h0200; cfg_len = 14'd7; cfg_sel = 2'd2;
        @(negedge clk);
        cmd_scan = 1'b0;
        repeat (2) @(negedge clk);
        check("r41_busy_before_rst", 32'(busy3), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("r41_rst_busy", 32'({busy1, busy3}), 32'd0);
        check("r41_rst_done", 32'({done1, done3}), 32'd0);
        check("r41_rst_rd", 32'({rd1, rd3}), 32'd0);
        check("r41_rst_sig", 32'({sig1, sig3}), 32'd0);
        check("r41_rst_addr", 32'({ra1, ra3}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
